// File: rtl/nios2_c_cpu_jtag_pkg.sv
// Shared types and constants for the Nios II JTAG debug scan master.
package nios2_c_cpu_jtag_pkg;

  localparam int unsigned DR_WIDTH_DEFAULT = 38;
  localparam int unsigned IR_WIDTH_DEFAULT = 2;

  // Virtual IR codes understood by the debug module
  localparam logic [1:0] IR_OCIMEM   = 2'b00;
  localparam logic [1:0] IR_TRACEMEM = 2'b01;
  localparam logic [1:0] IR_BREAK    = 2'b10;
  localparam logic [1:0] IR_ENABLE   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RSP
  } jtag_state_e;

  // True while tck should be toggling
  function automatic logic state_active(jtag_state_e s);
    return (s != ST_IDLE) && (s != ST_RSP);
  endfunction

  // Counter width able to hold 0..n-1, never below one bit
  function automatic int unsigned cnt_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nios2_c_cpu_jtag_scan_master_if.sv
// Command/response bus between a host and the JTAG scan master.
interface nios2_c_cpu_jtag_scan_master_if
  import nios2_c_cpu_jtag_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEFAULT
) ();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

endinterface

// File: rtl/nios2_c_cpu_jtag_tck_gen.sv
// Divided test-clock generator: low half first, restarts low whenever re-enabled.
module nios2_c_cpu_jtag_tck_gen
  import nios2_c_cpu_jtag_pkg::*;
#(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_c_o,
  output logic tck_fall_c_o
);

  localparam int unsigned PERIOD = 2 * TCK_DIV;
  localparam int unsigned CW     = cnt_width(PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != CW'(PERIOD - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end
    tck_d = en_i && (cnt_d >= CW'(TCK_DIV));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  // Strobes mark the clk edge on which tck rises / a period ends
  assign tck_rise_c_o = en_i && (cnt_q == CW'(TCK_DIV - 1));
  assign tck_fall_c_o = en_i && (cnt_q == CW'(PERIOD - 1));
  assign tck_o        = tck_q;

endmodule

// File: rtl/nios2_c_cpu_jtag_scan_master.sv
// Host-side virtual-JTAG initiator for the Nios II debug module.
// Optional IR caching (skip UIR on unchanged IR): define NIOS2_C_JTAG_SCAN_IR_CACHE_EN.
module nios2_c_cpu_jtag_scan_master
  import nios2_c_cpu_jtag_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DR_WIDTH_DEFAULT,
  parameter int unsigned IR_WIDTH   = IR_WIDTH_DEFAULT,
  parameter int unsigned TCK_DIV    = 2,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  nios2_c_cpu_jtag_scan_master_if.slave cmd_bus,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int unsigned CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  jtag_state_e         state_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic                rsp_valid_q;
  logic                cmd_ready_q;
  logic                tdi_q;
  logic                vs_uir_q, vs_cdr_q, vs_sdr_q, vs_udr_q, rti_q;
`ifdef NIOS2_C_JTAG_SCAN_IR_CACHE_EN
  logic                ir_valid_q;
`endif

  logic phase_en;
  logic tck_rise, tck_fall;

  assign phase_en = state_active(state_q);

  nios2_c_cpu_jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (phase_en),
    .tck_o        (tck),
    .tck_rise_c_o (tck_rise),
    .tck_fall_c_o (tck_fall)
  );

  // Phase sequencer; every phase change happens on a period-end strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      rsp_dr_q    <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      tdi_q       <= 1'b0;
      vs_uir_q    <= 1'b0;
      vs_cdr_q    <= 1'b0;
      vs_sdr_q    <= 1'b0;
      vs_udr_q    <= 1'b0;
      rti_q       <= 1'b0;
`ifdef NIOS2_C_JTAG_SCAN_IR_CACHE_EN
      ir_valid_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_bus.cmd_valid) begin
            shift_q     <= cmd_bus.cmd_dr;
            cmd_ready_q <= 1'b0;
`ifdef NIOS2_C_JTAG_SCAN_IR_CACHE_EN
            if (ir_valid_q && (cmd_bus.cmd_ir == ir_in_q)) begin
              state_q  <= ST_CDR;
              vs_cdr_q <= 1'b1;
            end else begin
              state_q  <= ST_UIR;
              vs_uir_q <= 1'b1;
              ir_in_q  <= cmd_bus.cmd_ir;
            end
`else
            state_q  <= ST_UIR;
            vs_uir_q <= 1'b1;
            ir_in_q  <= cmd_bus.cmd_ir;
`endif
          end
        end
        ST_UIR: begin
          if (tck_fall) begin
            state_q  <= ST_CDR;
            vs_uir_q <= 1'b0;
            vs_cdr_q <= 1'b1;
          end
        end
        ST_CDR: begin
          if (tck_rise) begin
            rsp_ir_q <= ir_out;
          end
          if (tck_fall) begin
            state_q  <= ST_SDR;
            vs_cdr_q <= 1'b0;
            vs_sdr_q <= 1'b1;
            tdi_q    <= shift_q[0];
            cnt_q    <= '0;
          end
        end
        ST_SDR: begin
          if (tck_rise) begin
            shift_q <= {tdo, shift_q[DR_WIDTH-1:1]};
          end
          if (tck_fall) begin
            if (cnt_q == CNT_W'(DR_WIDTH - 1)) begin
              state_q  <= ST_UDR;
              vs_sdr_q <= 1'b0;
              vs_udr_q <= 1'b1;
              tdi_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              tdi_q <= shift_q[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
            state_q  <= ST_RTI;
            vs_udr_q <= 1'b0;
            rti_q    <= 1'b1;
            cnt_q    <= '0;
          end
        end
        ST_RTI: begin
          if (tck_fall) begin
            if (cnt_q == CNT_W'(RTI_CYCLES - 1)) begin
              state_q     <= ST_RSP;
              rti_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_dr_q    <= shift_q;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RSP: begin
          if (cmd_bus.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef NIOS2_C_JTAG_SCAN_IR_CACHE_EN
            ir_valid_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_bus.cmd_ready  = cmd_ready_q;
  assign cmd_bus.rsp_valid  = rsp_valid_q;
  assign cmd_bus.rsp_dr     = rsp_dr_q;
  assign cmd_bus.rsp_ir_out = rsp_ir_q;
  assign tdi                = tdi_q;
  assign ir_in              = ir_in_q;
  assign vs_uir             = vs_uir_q;
  assign vs_cdr             = vs_cdr_q;
  assign vs_sdr             = vs_sdr_q;
  assign vs_udr             = vs_udr_q;
  assign jtag_state_rti     = rti_q;

endmodule

// File: tb/tb_nios2_c_cpu_jtag_scan_master.sv
// Scoreboard bench for the JTAG scan master against a behavioural scan-chain target.
module tb_nios2_c_cpu_jtag_scan_master;
  import nios2_c_cpu_jtag_pkg::*;

  localparam int unsigned DRW = 38;
  localparam int unsigned IRW = 2;
  localparam int unsigned DIV = 2;
  localparam int unsigned RTI = 2;
  localparam int unsigned PER = 2 * DIV;
`ifdef NIOS2_C_JTAG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic           tck, tdi, tdo;
  logic [IRW-1:0] ir_in;
  logic [IRW-1:0] ir_out = '0;
  logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  nios2_c_cpu_jtag_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();

  nios2_c_cpu_jtag_scan_master #(
    .DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(DIV), .RTI_CYCLES(RTI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_bus(bus),
    .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(jtag_state_rti)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Behavioural target: a DR-long shift chain, LSB out on tdo, tdi into MSB on tck rise
  logic [DRW-1:0] tgt = '0;
  logic [DRW-1:0] tgt_val = '0;
  logic           tgt_load = 1'b0;
  logic           tdo_force = 1'b0;
  logic           tck_d = 1'b0;
  always @(posedge clk) begin
    tck_d <= tck;
    if (tgt_load) tgt <= tgt_val;
    else if (tck && !tck_d && vs_sdr) tgt <= {tdi, tgt[DRW-1:1]};
  end
  assign tdo = tdo_force ? 1'b1 : tgt[0];

  // Response consumer: 0 always ready, 1 random, 2 never
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b1;
      1:       bus.rsp_ready = 1'($urandom_range(0, 1));
      default: bus.rsp_ready = 1'b0;
    endcase
  end

  typedef struct {
    logic [DRW-1:0] dr_exp;
    logic [IRW-1:0] irout_exp;
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr_in;
    int             lat;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [DRW-1:0] m_tgt = '0;
  logic [IRW-1:0] m_ir_in = '0;
  bit             m_done = 1'b0;
  int             m_uir = 0;
  int             uir_seen = 0;

  // Monitor: latency, response contents, phase one-hot and pulse widths
  int   hs_cyc = 0;
  bit   prev_rv = 1'b0;
  int   wc[5];
  int   wexp[5] = '{PER, PER, PER * DRW, PER, PER * RTI};
  exp_t e;
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) wc[i] = 0;
      prev_rv = 1'b0;
    end else begin
      bit v[5];
      int hot;
      bit idle_like;
      v = '{vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti};
      if (bus.cmd_valid && bus.cmd_ready) hs_cyc = cyc + 1;
      if (bus.rsp_valid && !prev_rv) begin
        if (sbq.size() > 0) chk("latency", 64'(cyc - hs_cyc), 64'(sbq[0].lat));
        else chk("unexpected_rsp", 64'(1), 64'(0));
      end
      prev_rv = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rsp_dr", 64'(bus.rsp_dr), 64'(e.dr_exp));
        chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(e.irout_exp));
        chk("ir_in_held", 64'(ir_in), 64'(e.ir));
        chk("tdi_serial", 64'(tgt), 64'(e.dr_in));
        m_done = 1'b1;
      end
      hot = 0;
      for (int i = 0; i < 5; i++) hot += int'(v[i]);
      idle_like = bus.cmd_ready || bus.rsp_valid;
      chk("phase_onehot", 64'(idle_like ? (hot == 0) : (hot == 1)), 64'(1));
      for (int i = 0; i < 5; i++) begin
        if (v[i]) wc[i]++;
        else if (wc[i] != 0) begin
          chk($sformatf("pulse_width_%0d", i), 64'(wc[i]), 64'(wexp[i]));
          if (i == 0) uir_seen++;
          wc[i] = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic issue(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                       input logic [IRW-1:0] irout);
    exp_t x;
    bit   cached;
    wait_ready();
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    ir_out        = irout;
    cached        = CACHE && m_done && (ir == m_ir_in);
    x.dr_exp      = tdo_force ? '1 : m_tgt;
    x.irout_exp   = irout;
    x.ir          = ir;
    x.dr_in       = dr;
    x.lat         = int'((3 + DRW + RTI - (cached ? 1 : 0)) * PER);
    if (!cached) m_uir++;
    m_ir_in = ir;
    m_tgt   = dr;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic preload(input logic [DRW-1:0] v);
    @(posedge clk);
    #1;
    tgt_val  = v;
    tgt_load = 1'b1;
    m_tgt    = v;
    @(posedge clk);
    #1;
    tgt_load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'(0));
  endtask

  function automatic logic [DRW-1:0] rnd_dr();
    return DRW'({$urandom, $urandom});
  endfunction

  initial begin
    logic [DRW-1:0] held;
    int             n;
    int             k;
    logic           prev;
    bit             any;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = '0;
    bus.cmd_dr    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("reset_tck", 64'(tck), 64'(0));
    chk("reset_ir_in", 64'(ir_in), 64'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // tdo tied high: capture is all ones, tdi carries the command word
    tdo_force = 1'b1;
    issue(IR_TRACEMEM, 38'h2A_5555_AAAA, 2'b00);
    drain();
    tdo_force = 1'b0;

    // Back-to-back against a preloaded target
    preload(38'h12_3456_789A);
    issue(IR_BREAK, rnd_dr(), 2'b10);
    issue(IR_OCIMEM, rnd_dr(), 2'b01);
    drain();

    // Response held off: outputs stable, stray commands ignored
    rdy_mode = 2;
    issue(IR_TRACEMEM, rnd_dr(), 2'b11);
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", 64'(bus.rsp_valid), 64'(1));
    held = bus.rsp_dr;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = IR_ENABLE;
    bus.cmd_dr    = rnd_dr();
    repeat (50) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("hold_rsp_dr", 64'(bus.rsp_dr), 64'(held));
      chk("hold_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      chk("hold_tck", 64'(tck), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset in the middle of the DR scan
    issue(IR_ENABLE, rnd_dr(), 2'b10);
    n = 0;
    while (!vs_sdr && n < 1000) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    prev = tck;
    while (k < 20 && n < 2000) begin
      @(negedge clk);
      n++;
      if (tck && !prev) k++;
      prev = tck;
    end
    while (tck && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_sdr", 64'(vs_sdr), 64'(1));
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_tck", 64'(tck), 64'(0));
    chk("abort_tdi", 64'(tdi), 64'(0));
    chk("abort_ir_in", 64'(ir_in), 64'(0));
    chk("abort_vs", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}), 64'(0));
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("abort_rsp_dr", 64'(bus.rsp_dr), 64'(0));
    chk("abort_rsp_ir_out", 64'(bus.rsp_ir_out), 64'(0));
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    void'(sbq.pop_back());
    m_ir_in = '0;
    m_done  = 1'b0;
    any = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (bus.rsp_valid) any = 1'b1;
    end
    chk("abort_no_rsp", 64'(any), 64'(0));
    preload(rnd_dr());
    issue(IR_OCIMEM, rnd_dr(), 2'b01);
    drain();

    // Repeated IR: UIR skipped only when caching is built in
    issue(IR_ENABLE, rnd_dr(), 2'b00);
    issue(IR_ENABLE, rnd_dr(), 2'b11);
    drain();

    // Randomised traffic with random consumer backpressure
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      issue(IRW'($urandom_range(0, 3)), rnd_dr(), IRW'($urandom_range(0, 3)));
    end
    drain();
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    chk("uir_pulse_count", 64'(uir_seen), 64'(m_uir));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios2_c_cpu_jtag_scan_master.md
# nios2_c_cpu_jtag_scan_master

Host-side initiator for the Nios II CPU JTAG debug module's virtual-JTAG interface, i.e. the driving end of the link the debug module normally receives from the SLD hub. It accepts a command (2-bit IR, 38-bit DR), sequences UIR → CDR → SDR → UDR → RTI phases on a divided tck, shifts the DR out on tdi while capturing tdo, and returns the captured DR. It sits beside the CPU in simulation and in hub-less builds, wired straight to the debug module's ir_in/ir_out/tck/tdi/tdo/vs_* pins.

## Interface
Parameters:
- DR_WIDTH, 38, scan-chain length in bits
- IR_WIDTH, 2, virtual IR width
- TCK_DIV, 2, clk cycles per tck half-period (≥1)
- RTI_CYCLES, 2, tck periods spent in run-test-idle after UDR (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_ir  in  IR_WIDTH  IR value to load
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first
- rsp_valid  out  1  captured data available
- rsp_ready  in  1  consumer accepts response
- rsp_dr  out  DR_WIDTH  captured tdo bits, first-captured at bit 0
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR
- tck  out  1  generated test clock
- tdi  out  1  serial data to target
- tdo  in  1  serial data from target
- ir_in  out  IR_WIDTH  IR to target, held between commands
- ir_out  in  IR_WIDTH  status from target
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual-state indicators
- jtag_state_rti  out  1  run-test-idle indicator

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RSP.
- IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd_ir, cmd_dr into shift register, goes to UIR.
- UIR: 1 tck period, vs_uir=1, ir_in←cmd_ir at phase entry.
- CDR: 1 tck period, vs_cdr=1; ir_out sampled into rsp_ir_out at tck rise.
- SDR: exactly DR_WIDTH tck periods, vs_sdr=1; tdi=shift[0]; at each tck rise shift right, tdo into MSB. After last period shift holds the captured word.
- UDR: 1 tck period, vs_udr=1.
- RTI: RTI_CYCLES tck periods, jtag_state_rti=1.
- RSP: rsp_valid=1, rsp_dr=shift; held until rsp_ready; handshake returns to IDLE next cycle.
- ir_in persists after a command; only UIR or reset changes it.
- Exactly one of vs_*/jtag_state_rti is high outside IDLE/RSP; all low in IDLE/RSP.

## Timing
- tck low for TCK_DIV clks, then high for TCK_DIV clks; every phase starts on a tck falling boundary (low half first). tck idles low in IDLE/RSP.
- tdi, vs_*, ir_in, jtag_state_rti change only at tck-low entry; tdo/ir_out sampled on the clk where tck goes high.
- Latency: rsp_valid rises (3+DR_WIDTH+RTI_CYCLES)·2·TCK_DIV clks after the cmd handshake cycle; defaults → 172 clks.
- rsp_ready may be high before rsp_valid; earliest response completes in the first RSP cycle.
- Reset (any state, including mid-SDR): next clk state=IDLE; tck, tdi, ir_in, vs_*, jtag_state_rti, rsp_valid, rsp_dr, rsp_ir_out all 0; cmd_ready=1 from the first cycle after reset. Partial scans are discarded, no response.
- cmd_valid outside IDLE ignored (cmd_ready=0).

## Configuration
- NIOS2_C_JTAG_SCAN_IR_CACHE_EN defined: if cmd_ir equals current ir_in and at least one command has completed since reset, UIR is skipped (latency reduced by 2·TCK_DIV clks; vs_uir never pulses).
- Undefined: UIR executed on every command.

## Structure
- Package nios2_c_cpu_jtag_pkg: state enum; IR codes OCIMEM=2'b00, TRACEMEM=2'b01, BREAK=2'b10, ENABLE=2'b11; DR_WIDTH default 38.
- Sub-module nios2_c_cpu_jtag_tck_gen: counter producing tck plus tck_rise/tck_fall single-clk strobes; enabled only outside IDLE/RSP, restarts low on enable.

## Test plan
- tdo tied 1, cmd ir=2'b01, dr=38'h2A_5555_AAAA -> rsp_dr=38'h3F_FFFF_FFFF, ir_in=2'b01, rsp_valid 172 clks after handshake, tdi serial = AAAA_5555_2A LSB first.
- Behavioral 38-bit target shift-register preloaded 38'h12_3456_789A, two back-to-back commands -> first rsp_dr=38'h12_3456_789A, second rsp_dr equals first cmd_dr.
- ir_out=2'b10 -> rsp_ir_out=2'b10; vs_uir/cdr/sdr/udr/rti pulse widths 4,4,152,4,8 clks, one-hot.
- rsp_ready held low 50 clks -> rsp_valid and rsp_dr stable, cmd_ready=0 throughout.
- reset_n low one clk during SDR bit 20 -> all outputs 0 next clk, no rsp_valid, next command completes normally.
- With NIOS2_C_JTAG_SCAN_IR_CACHE_EN, two commands ir=2'b11 -> second has no vs_uir pulse, latency 168 clks; without macro, 172.
